// File: rtl/aes_pkg.sv
// Shared definitions for the AES request arbiter: FSM encoding, block width, default watchdog.
package aes_pkg;

    localparam int AES_BLK_W           = 128;
    localparam int DEFAULT_TIMEOUT_CYC = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Width of a counter that must be able to hold the value lim.
    function automatic int cnt_width(input int lim);
        return (lim < 2) ? 1 : $clog2(lim) + 1;
    endfunction

endpackage

// File: rtl/aes_req_arbiter_if.sv
// Request, core and response signals of the shared AES core arbiter.
interface aes_req_arbiter_if
    import aes_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*AES_BLK_W-1:0] req_pt;
    logic [NUM_REQ*AES_BLK_W-1:0] req_key;

    logic                 core_start;
    logic [AES_BLK_W-1:0] core_pt;
    logic [AES_BLK_W-1:0] core_key;
    logic                 core_done;
    logic [AES_BLK_W-1:0] core_ct;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [AES_BLK_W-1:0] rsp_data;
    logic                 rsp_err;

    logic                 spurious_done;

    // Arbiter side.
    modport master (
        input  req_valid, req_pt, req_key, core_done, core_ct, rsp_ready,
        output req_ready, core_start, core_pt, core_key,
               rsp_valid, rsp_id, rsp_data, rsp_err, spurious_done
    );

    // Requesters, AES core and response consumer.
    modport slave (
        output req_valid, req_pt, req_key, core_done, core_ct, rsp_ready,
        input  req_ready, core_start, core_pt, core_key,
               rsp_valid, rsp_id, rsp_data, rsp_err, spurious_done
    );

endinterface

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin picker: first valid requester after ptr, with wrap-around.
module aes_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        // Offsets 1..NUM_REQ visit every requester once, ending on ptr itself.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any && (i == cand) && valid[i]) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    idx      = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one iterative AES-128 core among NUM_REQ requesters with round-robin
// arbitration, a done watchdog and an ID-tagged valid/ready response.
module aes_req_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_req_arbiter_if.master bus
);

    localparam int TIMER_W = cnt_width(TIMEOUT_CYC);

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      id_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [AES_BLK_W-1:0] pt_q, key_q, data_q;
    logic                 err_q;
    logic                 spur_q;

    logic [NUM_REQ-1:0]   win_grant;
    logic [ID_W-1:0]      win_idx;
    logic                 win_any;
    logic                 accept;
    logic                 timeout_hit;
    logic [AES_BLK_W-1:0] pt_sel, key_sel;

    aes_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_rr (
        .valid (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // The arbiter only grants valid requesters, so a grant in IDLE is an accept.
    assign accept      = (state_q == ST_IDLE) && win_any;
    assign timeout_hit = (timer_q == TIMER_W'(TIMEOUT_CYC - 1));

    always_comb begin
        pt_sel  = '0;
        key_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_grant[i]) begin
                pt_sel  = pt_sel  | bus.req_pt [i*AES_BLK_W +: AES_BLK_W];
                key_sel = key_sel | bus.req_key[i*AES_BLK_W +: AES_BLK_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.req_ready  = '0;
        bus.core_start = 1'b0;
        bus.rsp_valid  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.req_ready = win_grant;
                if (win_any) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.core_start = 1'b1;
                state_d        = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.core_done || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accept: capture the winner's block and key, and move priority past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            id_q     <= '0;
            pt_q     <= '0;
            key_q    <= '0;
        end else if (accept) begin
            rr_ptr_q <= win_idx;
            id_q     <= win_idx;
            pt_q     <= pt_sel;
            key_q    <= key_sel;
        end
    end

    // Watchdog: cleared while the start pulse is out, counts through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            timer_q <= '0;
        end else if (state_q == ST_WAIT) begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    // Completion: a done in the final watchdog cycle still wins over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (state_q == ST_WAIT) begin
            if (bus.core_done) begin
                data_q <= bus.core_ct;
                err_q  <= 1'b0;
            end else if (timeout_hit) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spur_q <= 1'b0;
        end else if (bus.core_done && (state_q != ST_WAIT)) begin
            spur_q <= 1'b1;
        end
    end

    assign bus.core_pt       = pt_q;
    assign bus.core_key      = key_q;
    assign bus.rsp_id        = id_q;
    assign bus.rsp_data      = data_q;
    assign bus.rsp_err       = err_q;
    assign bus.spurious_done = spur_q;

endmodule
